// File: rtl/rx_frame_deser.sv
// Receive-side frame deserializer: assembles strobed line bits into a word,
// checks optional parity and the stop bit, and holds the result for a ready/valid consumer.
module rx_frame_deser #(
  parameter int MAX_WIDTH = 9,
  parameter int LEN_W     = 4
) (
  input  logic                 clk_RX,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 bit_stb,
  input  logic                 sampled_bit,
  input  logic [LEN_W-1:0]     data_len,
  input  logic                 msb_first,
  input  logic                 par_en,
  input  logic                 par_typ,
  input  logic                 out_ready,
  output logic [MAX_WIDTH-1:0] P_DATA,
  output logic                 data_valid,
  output logic                 par_err,
  output logic                 stp_err,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(5);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WIDTH);

  state_t               state, state_nxt;
  logic [LEN_W-1:0]     len_q, cnt, len_clamp, idx;
  logic                 msb_q, pen_q, ptyp_q, perr_q;
  logic [MAX_WIDTH-1:0] shreg;
  logic                 stb, done;

  always_comb begin
    len_clamp = data_len;
    if (data_len < MIN_LEN)      len_clamp = MIN_LEN;
    else if (data_len > MAX_LEN) len_clamp = MAX_LEN;
  end

  // abort outranks any strobe arriving in the same cycle
  assign stb  = bit_stb && !abort;
  assign idx  = msb_q ? (len_q - LEN_W'(1) - cnt) : cnt;
  assign done = (state == STOP) && stb;
  assign busy = (state != IDLE);

  always_ff @(posedge clk_RX or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort && state != IDLE) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:   if (start) state_nxt = DATA;
        DATA:   if (bit_stb && cnt == len_q - LEN_W'(1)) state_nxt = pen_q ? PARITY : STOP;
        PARITY: if (bit_stb) state_nxt = STOP;
        STOP:   if (bit_stb) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_RX or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      msb_q      <= 1'b0;
      pen_q      <= 1'b0;
      ptyp_q     <= 1'b0;
      perr_q     <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len_q  <= len_clamp;
          msb_q  <= msb_first;
          pen_q  <= par_en;
          ptyp_q <= par_typ;
          perr_q <= 1'b0;
          cnt    <= '0;
          shreg  <= '0;
        end
        // shreg is cleared at start, so OR-ing each bit into place is enough
        DATA: if (stb) begin
          shreg <= shreg | (MAX_WIDTH'(sampled_bit) << idx);
          cnt   <= cnt + LEN_W'(1);
        end
        PARITY: if (stb) perr_q <= sampled_bit ^ (^shreg) ^ ptyp_q;
        default: ;
      endcase

      if (done) begin
        if (!data_valid || out_ready) begin
          P_DATA     <= shreg;
          par_err    <= perr_q;
          stp_err    <= ~sampled_bit;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && out_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_deser.sv
// Directed bench for rx_frame_deser: drives frames bit by bit and checks
// the delivered word, error flags and handshake against hand-computed values.
module tb_rx_frame_deser;
  localparam int MW = 9;
  localparam int LW = 4;

  logic          clk_RX = 1'b0;
  logic          rst, start, abort, bit_stb, sampled_bit;
  logic [LW-1:0] data_len;
  logic          msb_first, par_en, par_typ, out_ready;
  logic [MW-1:0] P_DATA;
  logic          data_valid, par_err, stp_err, overrun, busy;
  int            checks = 0;
  int            errors = 0;

  rx_frame_deser #(.MAX_WIDTH(MW), .LEN_W(LW)) dut (
    .clk_RX(clk_RX), .rst(rst), .start(start), .abort(abort), .bit_stb(bit_stb),
    .sampled_bit(sampled_bit), .data_len(data_len), .msb_first(msb_first),
    .par_en(par_en), .par_typ(par_typ), .out_ready(out_ready), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk_RX = ~clk_RX;

  task automatic tick();
    @(posedge clk_RX); #1;
  endtask

  task automatic stb(input logic b);
    sampled_bit = b; bit_stb = 1'b1; tick(); bit_stb = 1'b0;
  endtask

  // start + data bits (+ parity); config inputs are scrambled after start to prove they are latched
  task automatic send_body(input logic [MW-1:0] d, input logic [LW-1:0] cfg_len, input int nbits,
                           input logic msb, input logic pen, input logic ptyp, input logic parbit);
    data_len = cfg_len; msb_first = msb; par_en = pen; par_typ = ptyp;
    start = 1'b1; tick(); start = 1'b0;
    data_len = '0; msb_first = ~msb; par_en = ~pen; par_typ = ~ptyp;
    for (int k = 0; k < nbits; k++) stb(msb ? d[nbits-1-k] : d[k]);
    if (pen) stb(parbit);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; bit_stb = 0; sampled_bit = 0; data_len = '0;
    msb_first = 0; par_en = 0; par_typ = 0; out_ready = 1'b1;
    #2;
    checks++; if (P_DATA !== 9'h000) begin errors++; $display("FAIL rst_pdata got %h exp 000", P_DATA); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_dv got %b exp 0", data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if ({par_err, stp_err, overrun} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {par_err, stp_err, overrun}); end
    tick(); tick(); rst = 1'b0; tick();
  endtask

  task automatic test_lsb_basic();
    send_body(9'h0a5, 4'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lsb_busy got %b exp 1", busy); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL lsb_early_dv got %b exp 0", data_valid); end
    stb(1'b1);
    checks++; if (P_DATA !== 9'h0a5) begin errors++; $display("FAIL lsb_pdata got %h exp 0a5", P_DATA); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL lsb_dv got %b exp 1", data_valid); end
    checks++; if ({par_err, stp_err} !== 2'b00) begin errors++; $display("FAIL lsb_err got %b exp 00", {par_err, stp_err}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lsb_idle got %b exp 0", busy); end
    tick();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL lsb_consume got %b exp 0", data_valid); end
  endtask

  task automatic test_msb_parity();
    // 0x35 has four ones: even parity bit should be 0, so sending 1 is an error
    send_body(9'h035, 4'd7, 7, 1'b1, 1'b1, 1'b0, 1'b1);
    stb(1'b1);
    checks++; if (P_DATA !== 9'h035) begin errors++; $display("FAIL msb_pdata got %h exp 035", P_DATA); end
    checks++; if ({par_err, stp_err} !== 2'b10) begin errors++; $display("FAIL msb_even_err got %b exp 10", {par_err, stp_err}); end
    tick();
    // odd parity for 0x35 wants a 1
    send_body(9'h035, 4'd7, 7, 1'b1, 1'b1, 1'b1, 1'b1);
    stb(1'b1);
    checks++; if (P_DATA !== 9'h035) begin errors++; $display("FAIL msb_odd_pdata got %h exp 035", P_DATA); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL msb_odd_perr got %b exp 0", par_err); end
    tick();
    // LSB-first, even parity, 0x0C3 (four ones) with correct bit 0
    send_body(9'h0c3, 4'd8, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    stb(1'b1);
    checks++; if ({P_DATA, par_err} !== {9'h0c3, 1'b0}) begin errors++; $display("FAIL lsb_even got %h/%b exp 0c3/0", P_DATA, par_err); end
    tick();
  endtask

  task automatic test_stop_err();
    send_body(9'h03c, 4'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    stb(1'b0);
    checks++; if (P_DATA !== 9'h03c) begin errors++; $display("FAIL stp_pdata got %h exp 03c", P_DATA); end
    checks++; if ({par_err, stp_err, data_valid} !== 3'b011) begin errors++; $display("FAIL stp_flags got %b exp 011", {par_err, stp_err, data_valid}); end
    tick();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_body(9'h011, 4'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0); stb(1'b1);
    checks++; if ({data_valid, P_DATA} !== {1'b1, 9'h011}) begin errors++; $display("FAIL ovr_first got %b/%h exp 1/011", data_valid, P_DATA); end
    send_body(9'h022, 4'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0); stb(1'b1);
    checks++; if (P_DATA !== 9'h011) begin errors++; $display("FAIL ovr_hold got %h exp 011", P_DATA); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b exp 1", overrun); end
    tick();
    checks++; if ({overrun, data_valid} !== 2'b01) begin errors++; $display("FAIL ovr_after got %b exp 01", {overrun, data_valid}); end
    out_ready = 1'b1; tick();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b exp 0", data_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_body(9'h00f, 4'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0); stb(1'b1);
    send_body(9'h1f0, 4'd9, 9, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1; stb(1'b1);
    checks++; if ({data_valid, P_DATA, overrun} !== {1'b1, 9'h1f0, 1'b0}) begin errors++; $display("FAIL b2b_load got %b/%h/%b exp 1/1f0/0", data_valid, P_DATA, overrun); end
    tick();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", data_valid); end
  endtask

  task automatic test_abort();
    data_len = 4'd8; msb_first = 0; par_en = 0; par_typ = 0;
    start = 1'b1; tick(); start = 1'b0;
    stb(1'b1); stb(1'b0); stb(1'b1);
    abort = 1'b1; bit_stb = 1'b1; sampled_bit = 1'b1; tick(); abort = 1'b0; bit_stb = 1'b0;
    checks++; if ({busy, data_valid} !== 2'b00) begin errors++; $display("FAIL abort_idle got %b exp 00", {busy, data_valid}); end
    checks++; if (P_DATA !== 9'h1f0) begin errors++; $display("FAIL abort_keep got %h exp 1f0", P_DATA); end
    send_body(9'h03c, 4'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0); stb(1'b1);
    checks++; if ({data_valid, P_DATA} !== {1'b1, 9'h03c}) begin errors++; $display("FAIL abort_next got %b/%h exp 1/03c", data_valid, P_DATA); end
    tick();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL abort_single got %b exp 0", data_valid); end
  endtask

  task automatic test_clamp();
    send_body(9'h015, 4'd2, 5, 1'b0, 1'b0, 1'b0, 1'b0); stb(1'b1);
    checks++; if ({data_valid, P_DATA} !== {1'b1, 9'h015}) begin errors++; $display("FAIL clamp_lo got %b/%h exp 1/015", data_valid, P_DATA); end
    tick();
    send_body(9'h1a5, 4'd15, 9, 1'b1, 1'b0, 1'b0, 1'b0); stb(1'b1);
    checks++; if ({data_valid, P_DATA} !== {1'b1, 9'h1a5}) begin errors++; $display("FAIL clamp_hi got %b/%h exp 1/1a5", data_valid, P_DATA); end
    tick();
  endtask

  task automatic test_ignore();
    stb(1'b1); stb(1'b0);
    checks++; if ({busy, data_valid} !== 2'b00) begin errors++; $display("FAIL idle_stb got %b exp 00", {busy, data_valid}); end
    // strobe coinciding with start carries a 0 that must not land in bit 0
    data_len = 4'd5; msb_first = 0; par_en = 0; par_typ = 0;
    start = 1'b1; bit_stb = 1'b1; sampled_bit = 1'b0; tick(); start = 1'b0; bit_stb = 1'b0;
    stb(1'b1); stb(1'b1);
    data_len = 4'd9; start = 1'b1; tick(); start = 1'b0;
    stb(1'b1); stb(1'b1); stb(1'b1);
    stb(1'b1);
    checks++; if ({data_valid, P_DATA} !== {1'b1, 9'h01f}) begin errors++; $display("FAIL ignore_frame got %b/%h exp 1/01f", data_valid, P_DATA); end
    tick();
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b0;
    send_body(9'h033, 4'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0); stb(1'b0);
    checks++; if ({data_valid, stp_err} !== 2'b11) begin errors++; $display("FAIL rstmid_pre got %b exp 11", {data_valid, stp_err}); end
    data_len = 4'd8; start = 1'b1; tick(); start = 1'b0;
    stb(1'b1); stb(1'b1);
    #2 rst = 1'b1; #1;
    checks++; if ({P_DATA, data_valid, par_err, stp_err, overrun, busy} !== 14'h0) begin errors++; $display("FAIL rstmid_clear got %h/%b%b%b%b%b exp 000/00000", P_DATA, data_valid, par_err, stp_err, overrun, busy); end
    tick(); tick(); rst = 1'b0; out_ready = 1'b1; tick();
    send_body(9'h05a, 4'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0); stb(1'b1);
    checks++; if ({data_valid, P_DATA, stp_err} !== {1'b1, 9'h05a, 1'b0}) begin errors++; $display("FAIL rstmid_next got %b/%h/%b exp 1/05a/0", data_valid, P_DATA, stp_err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lsb_basic();
    test_msb_parity();
    test_stop_err();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_clamp();
    test_ignore();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
